// File: rtl/trace_dump_controller_if.sv
// Valid/ready beat stream carrying trace entries out of the dump controller.
interface trace_dump_controller_if #(
  parameter int W = 256
);
  logic         dump_valid;
  logic         dump_ready;
  logic [W-1:0] dump_data;
  logic         dump_cf;
  logic         dump_last;

  modport master (output dump_valid, dump_data, dump_cf, dump_last, input dump_ready);
  modport slave  (input dump_valid, dump_data, dump_cf, dump_last, output dump_ready);
endinterface

// File: rtl/trace_dump_controller.sv
// Enables/counts trace capture while idle; on dump_start freezes the circular
// trace buffer and streams its valid entries oldest-first with backpressure.
module trace_dump_controller #(
  parameter int N            = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int TB_SIZE      = 64,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2,
  localparam int AW = $clog2(TB_SIZE),
  localparam int CW = $clog2(TB_SIZE + 1),
  localparam int W  = N * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trace_enable,
  input  logic                         dump_start,
  input  logic                         tb_wr_commit,
  input  logic [AW-1:0]                tb_ptr_in,
  output logic                         tracing,
  output logic [AW-1:0]                tb_read_address,
  input  logic [W-1:0]                 tb_data_in,
  input  logic                         tb_cf_in,
  trace_dump_controller_if.master      dump,
  output logic                         busy,
  output logic                         dump_done
);
  localparam int FW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(TB_SIZE);

  typedef enum logic [1:0] {IDLE, FREEZE, READ, DONE} state_e;

  state_e                state_q;
  logic [CW-1:0]         fill_q, issue_left_q, beats_left_q;
  logic [AW-1:0]         rd_ptr_q, addr_q, rd_ptr_d;
  logic                  tracing_q, busy_q, done_q;
  logic [READ_LATENCY:0] vld_pipe_q;
  logic [W:0]            fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]         wr_idx_q, rd_idx_q;
  logic [FCW-1:0]        fcnt_q;
  logic                  push, pop, issue, credit_ok;
  int                    inflight;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(TB_SIZE - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  // Credit counts every read already issued but not yet in the FIFO; a pop
  // this cycle frees a slot, which keeps the stream bubble-free.
  always_comb begin
    inflight = 0;
    for (int i = 0; i <= READ_LATENCY; i++) inflight += int'(vld_pipe_q[i]);
  end

  assign push      = vld_pipe_q[READ_LATENCY];
  assign pop       = dump.dump_valid & dump.dump_ready;
  assign credit_ok = (int'(fcnt_q) + inflight - int'(pop)) < FIFO_DEPTH;
  assign issue     = (state_q == READ) && (issue_left_q != '0) && credit_ok;
  assign rd_ptr_d  = (fill_q == FULL) ? ptr_inc(tb_ptr_in) : '0;

  assign dump.dump_valid = (fcnt_q != '0);
  assign dump.dump_data  = fifo_mem[rd_idx_q][W-1:0];
  assign dump.dump_cf    = fifo_mem[rd_idx_q][W];
  assign dump.dump_last  = dump.dump_valid && (beats_left_q == CW'(1));
  assign tracing         = tracing_q;
  assign tb_read_address = addr_q;
  assign busy            = busy_q;
  assign dump_done       = done_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx_q] <= {tb_cf_in, tb_data_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= '0;
      tracing_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_pipe_q   <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      fcnt_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      vld_pipe_q <= {vld_pipe_q[READ_LATENCY-1:0], issue};
      if (push) wr_idx_q <= fifo_inc(wr_idx_q);
      if (pop)  rd_idx_q <= fifo_inc(rd_idx_q);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + FCW'(1);
        2'b01:   fcnt_q <= fcnt_q - FCW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (issue) begin
        addr_q       <= rd_ptr_q;
        rd_ptr_q     <= ptr_inc(rd_ptr_q);
        issue_left_q <= issue_left_q - CW'(1);
      end
      if (pop) beats_left_q <= beats_left_q - CW'(1);

      case (state_q)
        IDLE: begin
          tracing_q <= trace_enable;
          if (tb_wr_commit && tracing_q && fill_q != FULL) fill_q <= fill_q + CW'(1);
          if (dump_start) begin
            tracing_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= FREEZE;
          end
        end
        // A commit coincident with dump_start has landed in fill_q/tb_ptr_in by now.
        FREEZE: begin
          rd_ptr_q     <= rd_ptr_d;
          issue_left_q <= fill_q;
          beats_left_q <= fill_q;
          if (fill_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
          end
        end
        READ: begin
          if (pop && beats_left_q == CW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          fill_q    <= '0;
          tracing_q <= trace_enable;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end
endmodule
